div_iter_unit: RTL and testbench
================================

// Module: div_iter_unit
// PURPOSE
//  Parametrised iterative integer divider; successor to the fixed 32-bit div core used by the ALU.
//  Generalised in width and radix; adds valid/ready handshakes on input and output, a result hold buffer,
//  a synchronous cancel for pipeline flush, and defined divide-by-zero results.
//  Sits in EX stage beside the ALU; EX stalls on in_ready/out_valid instead of a bare complete pulse.
// PARAMETERS
//  WIDTH           32  operand/result width in bits; >= 4, even
//  BITS_PER_CYCLE  1   quotient bits retired per CALC cycle; 1 or 2; WIDTH % BITS_PER_CYCLE == 0
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  cancel        in   1      synchronous flush; abort any operation, drop result
//  in_valid      in   1      operands valid
//  in_ready      out  1      unit can accept operands
//  is_signed     in   1      1: two's-complement divide, 0: unsigned
//  dividend      in   WIDTH  numerator
//  divisor       in   WIDTH  denominator
//  out_valid     out  1      result valid, held until accepted
//  out_ready     in   1      consumer takes result
//  quotient      out  WIDTH  result quotient
//  remainder     out  WIDTH  result remainder
//  div_by_zero   out  1      result came from divisor == 0
//  busy          out  1      state != IDLE
// BEHAVIOUR
//  - States IDLE, CALC, FIX, DONE; N = WIDTH/BITS_PER_CYCLE.
//  - Reset: state IDLE; quotient, remainder, div_by_zero, out_valid = 0; iteration counter = 0.
//  - in_ready = (state == IDLE) & ~cancel; accept = in_valid & in_ready; operands latched on accept.
//  - IDLE -> CALC on accept with divisor != 0; IDLE -> DONE on accept with divisor == 0.
//  - Accept latches |dividend| and |divisor| as WIDTH-bit unsigned magnitudes (|MIN| = 2^(WIDTH-1)), plus
//    qneg = is_signed & (dividend[MSB] ^ divisor[MSB]) and rneg = is_signed & dividend[MSB].
//  - CALC: restoring shift-subtract, BITS_PER_CYCLE steps per cycle, MSB first; counter counts 0..N-1;
//    CALC -> FIX after the cycle with counter == N-1.
//  - FIX: negate quotient if qneg, remainder if rneg (truncating division; remainder sign = dividend sign);
//    register results; FIX -> DONE.
//  - Latency: out_valid rises exactly N+2 cycles after the accept edge (cycle count includes FIX);
//    divide-by-zero: out_valid rises 1 cycle after the accept edge.
//  - Divide-by-zero: quotient = all ones, remainder = dividend (unmodified, either signedness),
//    div_by_zero = 1. For every non-zero divisor, div_by_zero = 0.
//  - Signed overflow MIN / -1: quotient = MIN, remainder = 0; falls out of the magnitude datapath, no special case.
//  - DONE: out_valid = 1; quotient/remainder/div_by_zero stable while out_ready = 0; in_ready = 0.
//    DONE -> IDLE on out_valid & out_ready; out_valid drops the next cycle; no back-to-back accept in the same cycle.
//  - cancel (any state): next state IDLE, out_valid = 0 next cycle, result discarded.
//    cancel + in_valid in IDLE: not accepted. cancel + out_ready in DONE: treated as accept-and-drop; both end in IDLE.
//  - Result registers keep their last value in IDLE/CALC/FIX; consumers qualify with out_valid only.
//  - Reset mid-operation: immediate IDLE, all outputs at reset values; no partial result ever appears.
//  - Operands change on inputs after accept have no effect on an operation in flight.
// TESTING
//  1. W=32, BPC=1, unsigned 100/7 -> q=14, r=2; out_valid rises exactly 34 cycles after accept.
//  2. Signed -7/2 (0xFFFFFFF9/0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; 7/-2 -> q=0xFFFFFFFD, r=1.
//  3. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0, div_by_zero=0; unsigned same -> q=0, r=0x80000000.
//  4. 5/0 (both signedness) -> q=0xFFFFFFFF, r=5, div_by_zero=1, out_valid 1 cycle after accept.
//  5. out_ready low 10 cycles in DONE -> outputs stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
//  6. cancel at CALC iteration 10, and separately reset at iteration 10 -> out_valid never rises; next op 0xFFFF/0x10
//     gives q=0xFFF, r=0xF. Rerun 1-4 with BPC=2 (latency 18) and WIDTH=8 (exhaustive vs model).

Source files
------------

// File: rtl/div_iter_unit.sv
// Iterative restoring integer divider with valid/ready handshakes, cancel and defined divide-by-zero.
// Retires BITS_PER_CYCLE quotient bits per CALC cycle on operand magnitudes, then fixes signs in FIX.
module div_iter_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cancel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg, r_reg, d_reg;
  logic [WIDTH-1:0] q_nxt, r_nxt;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [CW-1:0]    count;
  logic             qneg, rneg;
  logic             accept;

  assign in_ready = (state == IDLE) & ~cancel;
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);

  // |MIN| wraps to 2^(WIDTH-1), which is exactly the unsigned magnitude wanted
  assign dividend_mag = (is_signed & dividend[WIDTH-1]) ? WIDTH'(~dividend + 1'b1) : dividend;
  assign divisor_mag  = (is_signed & divisor[WIDTH-1])  ? WIDTH'(~divisor + 1'b1)  : divisor;

  // q_reg shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    q_nxt = q_reg;
    r_nxt = r_reg;
    trial = '0;
    for (int k = 0; k < int'(BITS_PER_CYCLE); k++) begin
      trial = {r_nxt, q_nxt[WIDTH-1]};
      q_nxt = {q_nxt[WIDTH-2:0], 1'b0};
      if (trial >= {1'b0, d_reg}) begin
        r_nxt    = WIDTH'(trial - {1'b0, d_reg});
        q_nxt[0] = 1'b1;
      end else begin
        r_nxt = trial[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      count       <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else if (cancel) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            qneg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg <= is_signed & dividend[WIDTH-1];
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              q_reg <= dividend_mag;
              d_reg <= divisor_mag;
              r_reg <= '0;
              count <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          q_reg <= q_nxt;
          r_reg <= r_nxt;
          count <= count + CW'(1);
          if (count == CW'(N - 1)) state <= FIX;
        end
        FIX: begin
          quotient    <= qneg ? WIDTH'(~q_reg + 1'b1) : q_reg;
          remainder   <= rneg ? WIDTH'(~r_reg + 1'b1) : r_reg;
          div_by_zero <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Bench for div_iter_unit: three instances (32/1, 32/2, 8/1) checked against an arithmetic model.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cancel;
  logic        is_signed;
  logic [31:0] dividend, divisor;
  logic [2:0]  iv, ordy;

  logic [31:0] q_a, r_a, q_b, r_b;
  logic [7:0]  q_c, r_c;
  logic        ir_a, ir_b, ir_c, ov_a, ov_b, ov_c;
  logic        dz_a, dz_b, dz_c, busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_a (
    .clk(clk), .reset(rst), .cancel(cancel), .in_valid(iv[0]), .in_ready(ir_a),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor), .out_valid(ov_a),
    .out_ready(ordy[0]), .quotient(q_a), .remainder(r_a), .div_by_zero(dz_a), .busy(busy_a));

  div_iter_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_b (
    .clk(clk), .reset(rst), .cancel(cancel), .in_valid(iv[1]), .in_ready(ir_b),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor), .out_valid(ov_b),
    .out_ready(ordy[1]), .quotient(q_b), .remainder(r_b), .div_by_zero(dz_b), .busy(busy_b));

  div_iter_unit #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_c (
    .clk(clk), .reset(rst), .cancel(cancel), .in_valid(iv[2]), .in_ready(ir_c),
    .is_signed(is_signed), .dividend(dividend[7:0]), .divisor(divisor[7:0]), .out_valid(ov_c),
    .out_ready(ordy[2]), .quotient(q_c), .remainder(r_c), .div_by_zero(dz_c), .busy(busy_c));

  function automatic int wd(input int d);
    return (d == 2) ? 8 : 32;
  endfunction

  function automatic int bpc(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic logic [31:0] get_q(input int d);
    case (d)
      0:       return q_a;
      1:       return q_b;
      default: return {24'b0, q_c};
    endcase
  endfunction

  function automatic logic [31:0] get_r(input int d);
    case (d)
      0:       return r_a;
      1:       return r_b;
      default: return {24'b0, r_c};
    endcase
  endfunction

  function automatic logic get_dz(input int d);
    case (d)
      0:       return dz_a;
      1:       return dz_b;
      default: return dz_c;
    endcase
  endfunction

  function automatic logic get_ov(input int d);
    case (d)
      0:       return ov_a;
      1:       return ov_b;
      default: return ov_c;
    endcase
  endfunction

  function automatic logic get_ir(input int d);
    case (d)
      0:       return ir_a;
      1:       return ir_b;
      default: return ir_c;
    endcase
  endfunction

  // Reference: plain truncating integer division on w-bit values held in longints
  function automatic void model(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint m, ua, ub, sa, sb;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    sa = ua;
    sb = ub;
    if (sgn && ((ua >> (w - 1)) & 1) == 1) sa = ua - (m + 1);
    if (sgn && ((ub >> (w - 1)) & 1) == 1) sb = ub - (m + 1);
    if (ub == 0) begin
      q  = 32'(m);
      r  = 32'(ua);
      dz = 1'b1;
    end else begin
      q  = 32'((sa / sb) & m);
      r  = 32'((sa % sb) & m);
      dz = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int d, input logic [31:0] a, input logic [31:0] b, input bit sgn,
                     input int hold, input string tag);
    logic [31:0] eq, er;
    logic        edz;
    int          lat, exp_lat;
    model(wd(d), sgn, a, b, eq, er, edz);
    exp_lat = edz ? 1 : wd(d) / bpc(d) + 2;
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    iv[d]     = 1'b1;
    chk({tag, ":in_ready"}, 64'(get_ir(d)), 64'd1);
    @(posedge clk);
    #1;
    iv[d]     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom);
    lat = 0;
    while (!get_ov(d) && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ":latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ":quotient"}, 64'(get_q(d)), 64'(eq));
    chk({tag, ":remainder"}, 64'(get_r(d)), 64'(er));
    chk({tag, ":div_by_zero"}, 64'(get_dz(d)), 64'(edz));
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({tag, ":hold_valid"}, 64'(get_ov(d)), 64'd1);
      chk({tag, ":hold_q"}, 64'(get_q(d)), 64'(eq));
      chk({tag, ":hold_in_ready"}, 64'(get_ir(d)), 64'd0);
    end
    @(negedge clk);
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    chk({tag, ":valid_drop"}, 64'(get_ov(d)), 64'd0);
    chk({tag, ":ready_back"}, 64'(get_ir(d)), 64'd1);
  endtask

  task automatic start_a(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = 1'b0;
    iv[0]     = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
  endtask

  task automatic watch_no_valid(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (ov_a) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          lat;
    rst = 1'b1; cancel = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0; iv = '0; ordy = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset:q", 64'(q_a), 64'd0);
    chk("reset:r", 64'(r_a), 64'd0);
    chk("reset:dz", 64'(dz_a), 64'd0);
    chk("reset:valid", 64'(ov_a), 64'd0);
    chk("reset:busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases on every instance
    for (int d = 0; d < 3; d++) begin
      run(d, 32'd100, 32'd7, 1'b0, 0, "u100_7");
      run(d, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s_m7_2");
      run(d, 32'd7, 32'hFFFF_FFFE, 1'b1, 0, "s_7_m2");
      run(d, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_min_m1");
      run(d, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_min_m1");
      run(d, 32'h0000_0080, 32'h0000_00FF, 1'b1, 0, "s8_min_m1");
      run(d, 32'd5, 32'd0, 1'b1, 0, "s_5_0");
      run(d, 32'd5, 32'd0, 1'b0, 0, "u_5_0");
      run(d, 32'h0000_FFFF, 32'h10, 1'b0, 0, "u_ffff_10");
    end

    // Result held while consumer stalls
    run(0, 32'd100, 32'd7, 1'b0, 10, "hold");
    run(0, 32'd5, 32'd0, 1'b0, 3, "hold_dz");

    // Cancel mid-CALC
    start_a(32'h1234_5678, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    chk("cancel:busy_before", 64'(busy_a), 64'd1);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    chk("cancel:busy_after", 64'(busy_a), 64'd0);
    watch_no_valid("cancel:no_valid");
    run(0, 32'h0000_FFFF, 32'h10, 1'b0, 0, "post_cancel");

    // Asynchronous reset mid-CALC
    start_a(32'h1234_5678, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid:q", 64'(q_a), 64'd0);
    chk("rst_mid:r", 64'(r_a), 64'd0);
    chk("rst_mid:busy", 64'(busy_a), 64'd0);
    chk("rst_mid:valid", 64'(ov_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_valid("rst_mid:no_valid");
    run(0, 32'h0000_FFFF, 32'h10, 1'b0, 0, "post_reset");

    // cancel with in_valid in IDLE is not an accept
    @(negedge clk);
    cancel = 1'b1;
    iv[0]  = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    #1;
    chk("cancel_idle:in_ready", 64'(ir_a), 64'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    iv[0]  = 1'b0;
    chk("cancel_idle:busy", 64'(busy_a), 64'd0);

    // cancel together with out_ready in DONE
    start_a(32'd9, 32'd3);
    lat = 0;
    while (!ov_a && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("cancel_done:valid_seen", 64'(ov_a), 64'd1);
    @(negedge clk);
    cancel  = 1'b1;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    cancel  = 1'b0;
    ordy[0] = 1'b0;
    chk("cancel_done:valid", 64'(ov_a), 64'd0);
    chk("cancel_done:busy", 64'(busy_a), 64'd0);

    // Randomised operations against the model
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < ((d == 2) ? 300 : 30); i++) begin
        ra = $urandom;
        case ($urandom_range(0, 7))
          0:       rb = 32'd0;
          1:       rb = 32'($urandom_range(1, 15));
          2:       rb = 32'hFFFF_FFFF;
          default: rb = $urandom;
        endcase
        if (d != 2 && $urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 28);
        run(d, ra, rb, 1'($urandom), 0, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
